// File: rtl/bsg_piso_ready_and_tx.sv
// Transmit-side serializer: accepts one wide word per ready_and handshake and
// emits it as els_p flits of width_p bits on a ready_and link with a last marker.
module bsg_piso_ready_and_tx #(
    parameter int width_p    = 8,
    parameter int els_p      = 4,
    parameter int hi_to_lo_p = 0,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic                       ready_and_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic                       last_o,
    input  logic                       ready_and_i,
    output logic                       busy_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [lg_els_lp-1:0] c_lastCnt = lg_els_lp'(els_p - 1);

    state_e                     r_state;
    state_e                     w_stateNext;
    logic [lg_els_lp-1:0]       r_cnt;
    logic [lg_els_lp-1:0]       w_cntNext;
    logic [els_p*width_p-1:0]   r_word;
    logic [els_p*width_p-1:0]   w_wordNext;
    logic                       w_send;
    logic                       w_last;
    logic                       w_xfer;
    logic                       w_accept;
    logic [lg_els_lp-1:0]       w_idx;
    logic [width_p-1:0]         w_flit;

    assign w_send   = (r_state == SEND);
    assign w_last   = w_send & (r_cnt == c_lastCnt);
    assign w_xfer   = w_send & ready_and_i;
    assign w_accept = v_i & ready_and_o;

    // Accepting on the last transfer lets a new word follow with no bubble.
    assign ready_and_o = (r_state == IDLE) | (w_xfer & w_last);
    assign v_o         = w_send;
    assign busy_o      = w_send;
    assign last_o      = w_last;

    assign w_idx = (hi_to_lo_p != 0) ? (c_lastCnt - r_cnt) : r_cnt;

    always_comb begin
        w_flit = '0;
        for (int k = 0; k < els_p; k++) begin
            if (w_idx == lg_els_lp'(k)) begin
                w_flit = r_word[k*width_p +: width_p];
            end
        end
    end

    assign data_o = w_send ? w_flit : '0;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_wordNext  = r_word;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_wordNext  = data_i;
                    w_cntNext   = '0;
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                if (ready_and_i) begin
                    if (w_last) begin
                        w_cntNext = '0;
                        if (w_accept) begin
                            w_wordNext  = data_i;
                            w_stateNext = SEND;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_cntNext = r_cnt + lg_els_lp'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_word  <= w_wordNext;
        end
    end

`ifndef SYNTHESIS
    logic r_stallPrev;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stallPrev <= 1'b0;
        end else begin
            r_stallPrev <= v_o & ~ready_and_i;
        end
    end

    // A stalled flit must still be offered on the following cycle.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (width_p > 0);
            assert (els_p > 0);
            assert (!r_stallPrev || v_o);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_piso_ready_and_tx.sv
// Bench for bsg_piso_ready_and_tx: three configurations (LSB-first, MSB-first,
// single-flit) checked against a remaining-flit-count reference model.
module tb_bsg_piso_ready_and_tx;

    logic        clk;
    logic        rstN;
    logic        vIn     [3];
    logic [31:0] dIn     [3];
    logic        rdyIn   [3];
    logic        rdyOut  [3];
    logic        vOut    [3];
    logic        lastOut [3];
    logic        busyOut [3];
    logic [7:0]  dOutA;
    logic [7:0]  dOutB;
    logic [15:0] dOutC;

    int checks = 0;
    int passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bsg_piso_ready_and_tx #(.width_p(8), .els_p(4), .hi_to_lo_p(0)) dutA (
        .clk_i(clk), .reset_n_i(rstN), .v_i(vIn[0]), .data_i(dIn[0]),
        .ready_and_o(rdyOut[0]), .v_o(vOut[0]), .data_o(dOutA),
        .last_o(lastOut[0]), .ready_and_i(rdyIn[0]), .busy_o(busyOut[0]));

    bsg_piso_ready_and_tx #(.width_p(8), .els_p(4), .hi_to_lo_p(1)) dutB (
        .clk_i(clk), .reset_n_i(rstN), .v_i(vIn[1]), .data_i(dIn[1]),
        .ready_and_o(rdyOut[1]), .v_o(vOut[1]), .data_o(dOutB),
        .last_o(lastOut[1]), .ready_and_i(rdyIn[1]), .busy_o(busyOut[1]));

    bsg_piso_ready_and_tx #(.width_p(16), .els_p(1), .hi_to_lo_p(0)) dutC (
        .clk_i(clk), .reset_n_i(rstN), .v_i(vIn[2]), .data_i(dIn[2][15:0]),
        .ready_and_o(rdyOut[2]), .v_o(vOut[2]), .data_o(dOutC),
        .last_o(lastOut[2]), .ready_and_i(rdyIn[2]), .busy_o(busyOut[2]));

    function automatic int elsOf(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int widOf(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic bit hiOf(input int d);
        return (d == 1);
    endfunction

    function automatic logic [31:0] maskOf(input int d);
        return (d == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [15:0] obsData(input int d);
        case (d)
            0:       return {8'h00, dOutA};
            1:       return {8'h00, dOutB};
            default: return dOutC;
        endcase
    endfunction

    // Flit number 'slot' of a word: plain shift-and-mask of the word.
    function automatic logic [15:0] flitOf(input int d, input logic [31:0] w, input int slot);
        logic [31:0] t;
        t = w >> (slot * widOf(d));
        if (widOf(d) == 16) return t[15:0];
        return {8'h00, t[7:0]};
    endfunction

    task automatic test_reset;
        rstN = 1'b1;
        for (int d = 0; d < 3; d++) begin
            vIn[d] = 1'b1; dIn[d] = 32'hA5A5_A5A5; rdyIn[d] = 1'b1;
        end
        #2 rstN = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({vOut[d], lastOut[d], busyOut[d], rdyOut[d], obsData(d)} !== {4'b0001, 16'h0000}) begin
                $display("[TB] FAIL reset_values dut%0d: got v/last/busy/rdy/data %b%b%b%b/%h expected 0001/0000",
                         d, vOut[d], lastOut[d], busyOut[d], rdyOut[d], obsData(d));
            end else passes++;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) vIn[d] = 1'b0;
        rstN = 1'b1;
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({vOut[d], rdyOut[d]} !== 2'b01) begin
                $display("[TB] FAIL reset_release dut%0d: got v/rdy %b%b expected 01", d, vOut[d], rdyOut[d]);
            end else passes++;
        end
    endtask

    task automatic test_order(input int d);
        logic [31:0] w;
        logic [15:0] e;
        w = 32'h4433_2211;
        @(negedge clk);
        vIn[d] = 1'b1; dIn[d] = w; rdyIn[d] = 1'b1;
        #1;
        checks++;
        if ({vOut[d], rdyOut[d]} !== 2'b01) begin
            $display("[TB] FAIL order_accept dut%0d: got v/rdy %b%b expected 01", d, vOut[d], rdyOut[d]);
        end else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vIn[d] = 1'b0;
            #1;
            e = flitOf(d, w, hiOf(d) ? 3 - i : i);
            checks++;
            if ({vOut[d], lastOut[d], busyOut[d], obsData(d)} !== {1'b1, (i == 3), 1'b1, e}) begin
                $display("[TB] FAIL order_flit dut%0d i=%0d: got v/last/busy/data %b%b%b/%h expected 1%b1/%h",
                         d, i, vOut[d], lastOut[d], busyOut[d], obsData(d), (i == 3), e);
            end else passes++;
        end
        @(negedge clk); #1;
        checks++;
        if ({vOut[d], rdyOut[d]} !== 2'b01) begin
            $display("[TB] FAIL order_done dut%0d: got v/rdy %b%b expected 01", d, vOut[d], rdyOut[d]);
        end else passes++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] w0, w1, w;
        logic [15:0] e;
        w0 = 32'h4433_2211; w1 = 32'h8877_6655;
        @(negedge clk);
        vIn[0] = 1'b1; dIn[0] = w0; rdyIn[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vIn[0] = (i <= 3); dIn[0] = w1;
            #1;
            w = (i < 4) ? w0 : w1;
            e = flitOf(0, w, i % 4);
            checks++;
            if ({vOut[0], lastOut[0], rdyOut[0], obsData(0)} !== {1'b1, (i % 4 == 3), (i % 4 == 3), e}) begin
                $display("[TB] FAIL b2b_flit i=%0d: got v/last/rdy/data %b%b%b/%h expected 1%b%b/%h",
                         i, vOut[0], lastOut[0], rdyOut[0], obsData(0), (i % 4 == 3), (i % 4 == 3), e);
            end else passes++;
        end
        @(negedge clk);
        vIn[0] = 1'b0;
        #1;
        checks++;
        if ({vOut[0], rdyOut[0]} !== 2'b01) begin
            $display("[TB] FAIL b2b_done: got v/rdy %b%b expected 01", vOut[0], rdyOut[0]);
        end else passes++;
    endtask

    task automatic test_backpressure;
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int k;
        logic [31:0] w;
        logic [15:0] e;
        w = 32'hDDCC_BBAA;
        k = 0;
        @(negedge clk);
        vIn[0] = 1'b1; dIn[0] = w; rdyIn[0] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vIn[0] = 1'b0; rdyIn[0] = pat[c][0];
            #1;
            e = flitOf(0, w, k);
            checks++;
            if ({vOut[0], lastOut[0], rdyOut[0], obsData(0)} !== {1'b1, (k == 3), (pat[c] == 1 && k == 3), e}) begin
                $display("[TB] FAIL stall_flit c=%0d: got v/last/rdy/data %b%b%b/%h expected 1%b%b/%h",
                         c, vOut[0], lastOut[0], rdyOut[0], obsData(0), (k == 3), (pat[c] == 1 && k == 3), e);
            end else passes++;
            if (pat[c] == 1) k++;
        end
        @(negedge clk);
        rdyIn[0] = 1'b1;
        #1;
        checks++;
        if ({vOut[0], rdyOut[0]} !== 2'b01) begin
            $display("[TB] FAIL stall_done: got v/rdy %b%b expected 01", vOut[0], rdyOut[0]);
        end else passes++;
    endtask

    task automatic test_reset_midword;
        logic [15:0] e;
        @(negedge clk);
        vIn[0] = 1'b1; dIn[0] = 32'h4433_2211; rdyIn[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vIn[0] = 1'b0;
            #1;
            e = flitOf(0, 32'h4433_2211, i);
            checks++;
            if ({vOut[0], obsData(0)} !== {1'b1, e}) begin
                $display("[TB] FAIL midrst_pre i=%0d: got v/data %b/%h expected 1/%h", i, vOut[0], obsData(0), e);
            end else passes++;
        end
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checks++;
        if ({vOut[0], lastOut[0], busyOut[0], obsData(0)} !== {3'b000, 16'h0000}) begin
            $display("[TB] FAIL midrst_async: got v/last/busy/data %b%b%b/%h expected 000/0000",
                     vOut[0], lastOut[0], busyOut[0], obsData(0));
        end else passes++;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({vOut[0], rdyOut[0]} !== 2'b01) begin
            $display("[TB] FAIL midrst_release: got v/rdy %b%b expected 01", vOut[0], rdyOut[0]);
        end else passes++;
        @(negedge clk);
        vIn[0] = 1'b1; dIn[0] = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vIn[0] = 1'b0;
            #1;
            e = (i == 0) ? 16'h0001 : 16'h0000;
            checks++;
            if ({vOut[0], lastOut[0], obsData(0)} !== {1'b1, (i == 3), e}) begin
                $display("[TB] FAIL midrst_next i=%0d: got v/last/data %b%b/%h expected 1%b/%h",
                         i, vOut[0], lastOut[0], obsData(0), (i == 3), e);
            end else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_els1;
        logic [15:0] words [2] = '{16'h1234, 16'h5678};
        @(negedge clk);
        vIn[2] = 1'b1; dIn[2] = {16'h0, words[0]}; rdyIn[2] = 1'b1;
        #1;
        checks++;
        if ({vOut[2], rdyOut[2]} !== 2'b01) begin
            $display("[TB] FAIL els1_accept: got v/rdy %b%b expected 01", vOut[2], rdyOut[2]);
        end else passes++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vIn[2] = (i == 0); dIn[2] = {16'h0, words[1]};
            #1;
            checks++;
            if ({vOut[2], lastOut[2], rdyOut[2], obsData(2)} !== {3'b111, words[i]}) begin
                $display("[TB] FAIL els1_flit i=%0d: got v/last/rdy/data %b%b%b/%h expected 111/%h",
                         i, vOut[2], lastOut[2], rdyOut[2], obsData(2), words[i]);
            end else passes++;
        end
        @(negedge clk); #1;
        checks++;
        if ({vOut[2], rdyOut[2]} !== 2'b01) begin
            $display("[TB] FAIL els1_done: got v/rdy %b%b expected 01", vOut[2], rdyOut[2]);
        end else passes++;
    endtask

    // Model per DUT: flits still owed for the current word, plus the word itself.
    task automatic test_random;
        int          rem  [3];
        logic [31:0] cur  [3];
        logic [31:0] asm  [3];
        int          pos  [3];
        logic [31:0] sentQ[3][$];
        int          sent0, done0, cyc, slot;
        bit          expV, expLast, expRdy;
        logic [15:0] expD, gotD;
        logic [31:0] want;
        for (int d = 0; d < 3; d++) begin
            rem[d] = 0; cur[d] = '0; asm[d] = '0; pos[d] = 0;
        end
        sent0 = 0; done0 = 0; cyc = 0;
        while (done0 < 1000 && cyc < 40000) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                vIn[d]   = (d == 0 && sent0 >= 1000) ? 1'b0 : ($urandom_range(0, 3) != 0);
                dIn[d]   = $urandom;
                rdyIn[d] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                expV    = (rem[d] > 0);
                expLast = (rem[d] == 1);
                expRdy  = (rem[d] == 0) || (rdyIn[d] && rem[d] == 1);
                expD    = expV ? flitOf(d, cur[d], hiOf(d) ? rem[d] - 1 : elsOf(d) - rem[d]) : 16'h0;
                gotD    = vOut[d] ? obsData(d) : 16'h0;
                checks++;
                if ({vOut[d], lastOut[d], rdyOut[d], busyOut[d], gotD} !== {expV, expLast, expRdy, expV, expD}) begin
                    $display("[TB] FAIL rand_cycle dut%0d cyc=%0d: got v/last/rdy/busy/data %b%b%b%b/%h expected %b%b%b%b/%h",
                             d, cyc, vOut[d], lastOut[d], rdyOut[d], busyOut[d], gotD, expV, expLast, expRdy, expV, expD);
                end else passes++;
                if (vOut[d] && rdyIn[d]) begin
                    slot = hiOf(d) ? elsOf(d) - 1 - pos[d] : pos[d];
                    asm[d] = asm[d] | (32'(obsData(d)) << (slot * widOf(d)));
                    pos[d]++;
                    if (lastOut[d]) begin
                        want = (sentQ[d].size() > 0) ? sentQ[d].pop_front() : 32'hxxxx_xxxx;
                        checks++;
                        if (asm[d] !== want) begin
                            $display("[TB] FAIL rand_word dut%0d: got %h expected %h", d, asm[d], want);
                        end else passes++;
                        asm[d] = '0; pos[d] = 0;
                        if (d == 0) done0++;
                    end
                end
                if (expV && rdyIn[d]) rem[d]--;
                if (vIn[d] && expRdy) begin
                    cur[d] = dIn[d] & maskOf(d);
                    rem[d] = elsOf(d);
                    sentQ[d].push_back(dIn[d] & maskOf(d));
                    if (d == 0) sent0++;
                end
            end
            cyc++;
        end
        checks++;
        if (done0 < 1000) begin
            $display("[TB] FAIL rand_timeout: got %0d words expected 1000", done0);
        end else passes++;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vIn[d] = 1'b0; rdyIn[d] = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_order(0);
        test_order(1);
        test_back_to_back();
        test_backpressure();
        test_reset_midword();
        test_els1();
        test_random();
        repeat (6) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
